// File: rtl/demux_edge_counter_if.sv
// Bus between a demux controller/bench and demux_edge_counter: demux lines in,
// readout/clear handshake, and the sticky multi-hot flag.
interface demux_edge_counter_if #(
  parameter int unsigned CNT_W = 8
);
  logic [3:0]       q;
  logic             rd_req;
  logic [1:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic             rd_ovf;
  logic             rd_valid;
  logic             clr;
  logic [1:0]       clr_sel;
  logic             multi_hot;
  logic             multi_hot_clr;

  modport master (
    output q, rd_req, rd_sel, clr, clr_sel, multi_hot_clr,
    input  rd_data, rd_ovf, rd_valid, multi_hot
  );

  modport slave (
    input  q, rd_req, rd_sel, clr, clr_sel, multi_hot_clr,
    output rd_data, rd_ovf, rd_valid, multi_hot
  );
endinterface

// File: rtl/demux_edge_counter.sv
// Per-channel saturating rising-edge counters on a 1-to-4 demux bus, with readout,
// per-channel clear and a sticky multi-hot flag. DEMUX_EDGE_COUNTER_SYNC_EN adds a 2-flop input synchronizer.
module demux_edge_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_edge_counter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0] q_in;

`ifdef DEMUX_EDGE_COUNTER_SYNC_EN
  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= bus.q;
      sync_q <= meta_q;
    end
  end

  assign q_in = sync_q;
`else
  assign q_in = bus.q;
`endif

  logic [3:0] q_s_q;
  logic [3:0] q_prev_q;
  logic [3:0] rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_s_q    <= '0;
      q_prev_q <= '0;
    end else begin
      q_s_q    <= q_in;
      q_prev_q <= q_s_q;
    end
  end

  assign rise = q_s_q & ~q_prev_q;

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       ovf_q;
  logic [3:0]       ovf_d;

  // Clear has priority over a same-cycle edge on the cleared channel.
  always_comb begin
    for (int unsigned ch = 0; ch < 4; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      ovf_d[ch] = ovf_q[ch];
      if (bus.clr && (bus.clr_sel == 2'(ch))) begin
        cnt_d[ch] = '0;
        ovf_d[ch] = 1'b0;
      end else if (rise[ch]) begin
        if (cnt_q[ch] == CNT_MAX) begin
          ovf_d[ch] = 1'b1;
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < 4; ch++) begin
        cnt_q[ch] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int unsigned ch = 0; ch < 4; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
      ovf_q <= ovf_d;
    end
  end

  logic             multi_hot_q;
  logic             multi_hot_d;

  always_comb begin
    multi_hot_d = multi_hot_q;
    if (bus.multi_hot_clr) begin
      multi_hot_d = 1'b0;
    end
    if ($countones(q_s_q) >= 2) begin
      multi_hot_d = 1'b1;
    end
  end

  logic [CNT_W-1:0] rd_data_q;
  logic [CNT_W-1:0] rd_data_d;
  logic             rd_ovf_q;
  logic             rd_ovf_d;
  logic             rd_valid_q;

  // Readout captures pre-update state, so same-cycle edges or clears are not seen.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_ovf_d  = rd_ovf_q;
    if (bus.rd_req) begin
      rd_data_d = cnt_q[bus.rd_sel];
      rd_ovf_d  = ovf_q[bus.rd_sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q   <= '0;
      rd_ovf_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      multi_hot_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      rd_ovf_q    <= rd_ovf_d;
      rd_valid_q  <= bus.rd_req;
      multi_hot_q <= multi_hot_d;
    end
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_ovf    = rd_ovf_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.multi_hot = multi_hot_q;

endmodule

// File: tb/tb_demux_edge_counter.sv
// Randomized and directed checks of demux_edge_counter against a sample-history reference model.
module tb_demux_edge_counter;

`ifdef DEMUX_EDGE_COUNTER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_edge_counter_if #(.CNT_W(8)) bus ();

  demux_edge_counter #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  int         cnt_m [4];
  bit         ovf_m [4];
  bit         mh_m;
  bit         ev_m;
  int         ed_m;
  bit         eo_m;
  logic [3:0] hist [$];
  int         last_data;
  int         last_ovf;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      cnt_m[i] = 0;
      ovf_m[i] = 0;
    end
    mh_m = 0; ev_m = 0; ed_m = 0; eo_m = 0;
    hist.delete();
    for (int i = 0; i <= LAT; i++) hist.push_back(4'b0);
  endtask

  // One clock: drive inputs, advance the model for that edge, then check outputs.
  task automatic tick(input logic [3:0] qv, input logic rq, input logic [1:0] rs,
                      input logic cl, input logic [1:0] cs, input logic mc);
    logic [3:0] qs, qp;
    bus.q = qv; bus.rd_req = rq; bus.rd_sel = rs;
    bus.clr = cl; bus.clr_sel = cs; bus.multi_hot_clr = mc;
    ev_m = rq;
    if (rq) begin
      ed_m = cnt_m[rs];
      eo_m = ovf_m[rs];
    end
    qs = hist[hist.size() - LAT];
    qp = hist[hist.size() - LAT - 1];
    if ($countones(qs) >= 2) mh_m = 1;
    else if (mc) mh_m = 0;
    for (int i = 0; i < 4; i++) begin
      if (cl && cs == 2'(i)) begin
        cnt_m[i] = 0;
        ovf_m[i] = 0;
      end else if (qs[i] && !qp[i]) begin
        if (cnt_m[i] == MAXC) ovf_m[i] = 1;
        else cnt_m[i] = cnt_m[i] + 1;
      end
    end
    hist.push_back(qv);
    void'(hist.pop_front());
    @(posedge clk);
    #1;
    check_val("rd_valid", int'(bus.rd_valid), int'(ev_m));
    check_val("rd_data", int'(bus.rd_data), ed_m);
    check_val("rd_ovf", int'(bus.rd_ovf), int'(eo_m));
    check_val("multi_hot", int'(bus.multi_hot), int'(mh_m));
    last_data = int'(bus.rd_data);
    last_ovf  = int'(bus.rd_ovf);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(4'b0, 0, 2'd0, 0, 2'd0, 0);
  endtask

  task automatic read_ch(input logic [1:0] sel);
    tick(4'b0, 1, sel, 0, 2'd0, 0);
  endtask

  task automatic clear_ch(input logic [1:0] sel);
    tick(4'b0, 0, 2'd0, 1, sel, 0);
  endtask

  task automatic pulses(input logic [3:0] qv, input int n);
    repeat (n) begin
      tick(qv, 0, 2'd0, 0, 2'd0, 0);
      tick(4'b0, 0, 2'd0, 0, 2'd0, 0);
    end
  endtask

  task automatic apply_reset();
    bus.q = '0; bus.rd_req = 0; bus.rd_sel = '0;
    bus.clr = 0; bus.clr_sel = '0; bus.multi_hot_clr = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    logic [3:0] pat [5];
    pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0100; pat[3] = 4'b1000; pat[4] = 4'b0000;

    apply_reset();
    check_val("reset_valid", int'(bus.rd_valid), 0);
    check_val("reset_data", int'(bus.rd_data), 0);
    check_val("reset_mh", int'(bus.multi_hot), 0);

    // Demux walk over selects 00..11, 100 ns per step.
    for (int p = 0; p < 5; p++) repeat (10) tick(pat[p], 0, 2'd0, 0, 2'd0, 0);
    idle(LAT + 1);
    for (int c = 0; c < 4; c++) begin
      read_ch(2'(c));
      check_val("walk_data", last_data, 1);
      check_val("walk_ovf", last_ovf, 0);
    end
    check_val("walk_mh", int'(bus.multi_hot), 0);

    // Saturation on channel 2.
    pulses(4'b0100, 300);
    idle(LAT + 1);
    read_ch(2'd2);
    check_val("sat_data", last_data, 255);
    check_val("sat_ovf", last_ovf, 1);
    clear_ch(2'd2);
    read_ch(2'd2);
    check_val("satclr_data", last_data, 0);
    check_val("satclr_ovf", last_ovf, 0);

    // Clear colliding with an edge on channel 1.
    clear_ch(2'd1);
    pulses(4'b0010, 5);
    idle(LAT + 1);
    read_ch(2'd1);
    check_val("pre_clr5", last_data, 5);
    tick(4'b0010, 0, 2'd0, 0, 2'd0, 0);
    repeat (LAT - 1) tick(4'b0010, 0, 2'd0, 0, 2'd0, 0);
    tick(4'b0010, 0, 2'd0, 1, 2'd1, 0);
    idle(LAT + 1);
    read_ch(2'd1);
    check_val("clr_edge", last_data, 0);

    // Read colliding with an edge on channel 3.
    clear_ch(2'd3);
    pulses(4'b1000, 7);
    idle(LAT + 1);
    tick(4'b1000, 0, 2'd0, 0, 2'd0, 0);
    repeat (LAT - 1) tick(4'b1000, 0, 2'd0, 0, 2'd0, 0);
    tick(4'b1000, 1, 2'd3, 0, 2'd0, 0);
    check_val("rd_edge_old", last_data, 7);
    tick(4'b0000, 1, 2'd3, 0, 2'd0, 0);
    check_val("rd_edge_new", last_data, 8);
    idle(LAT + 1);

    // Multi-hot detection and clear.
    clear_ch(2'd1);
    clear_ch(2'd2);
    tick(4'b0110, 0, 2'd0, 0, 2'd0, 0);
    idle(LAT + 1);
    check_val("mh_set", int'(bus.multi_hot), 1);
    read_ch(2'd1);
    check_val("mh_ch1", last_data, 1);
    read_ch(2'd2);
    check_val("mh_ch2", last_data, 1);
    tick(4'b0, 0, 2'd0, 0, 2'd0, 1);
    check_val("mh_clr", int'(bus.multi_hot), 0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [3:0] qv;
      r = $urandom_range(0, 9);
      if (r < 5) qv = 4'(1 << $urandom_range(0, 3));
      else if (r < 8) qv = 4'b0;
      else qv = 4'($urandom_range(0, 15));
      tick(qv, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset while a read is being presented.
    pulses(4'b0001, 3);
    idle(LAT + 1);
    tick(4'b0, 1, 2'd0, 0, 2'd0, 0);
    check_val("pre_rst_valid", int'(bus.rd_valid), 1);
    #2 rst_n = 0;
    #1;
    check_val("arst_valid", int'(bus.rd_valid), 0);
    check_val("arst_data", int'(bus.rd_data), 0);
    check_val("arst_ovf", int'(bus.rd_ovf), 0);
    check_val("arst_mh", int'(bus.multi_hot), 0);
    bus.rd_req = 0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    idle(LAT + 2);
    for (int c = 0; c < 4; c++) begin
      read_ch(2'(c));
      check_val("post_rst", last_data, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
